// File: rtl/sq_wave_sequencer.sv
// Table-driven sequencer for an external square-wave generator.
// Each of four entries loads an m/n duration pair and runs for a fixed number of q_in periods.
module sq_wave_sequencer #(
  parameter int N     = 4,
  parameter int CW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [N-1:0]  wr_m,
  input  logic [N-1:0]  wr_n,
  input  logic [CW-1:0] wr_reps,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [1:0]    last_idx,
  input  logic          q_in,
  output logic [N-1:0]  m_out,
  output logic [N-1:0]  n_out,
  output logic          gen_reset,
  output logic          busy,
  output logic          done,
  output logic [1:0]    cur_idx
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  logic [N-1:0]  r_tbl_m    [DEPTH];
  logic [N-1:0]  r_tbl_n    [DEPTH];
  logic [CW-1:0] r_tbl_reps [DEPTH];

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic          r_all_zero, w_all_zero_nxt;
  logic [CW-1:0] r_cnt, r_reps, w_cnt_inc;
  logic          r_q_prev;
  logic [N-1:0]  r_m, r_n;
  logic          r_gen_reset;
  logic          w_rise, w_adv;

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_all_zero_nxt = r_all_zero;
    w_adv          = 1'b0;
    w_rise         = q_in & ~r_q_prev;
    w_cnt_inc      = r_cnt + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt    = S_LOAD;
          w_idx_nxt      = 2'd0;
          w_all_zero_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        if (r_tbl_reps[r_idx] == '0) begin
          w_adv = 1'b1;
        end else begin
          w_state_nxt    = S_RUN;
          w_all_zero_nxt = 1'b0;
        end
      end
      S_RUN: begin
        // r_reps is nonzero here, so w_cnt_inc cannot wrap before matching it
        if (w_rise && (w_cnt_inc == r_reps)) w_adv = 1'b1;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_adv) begin
      if (r_idx < last_idx) begin
        w_idx_nxt   = r_idx + 1'b1;
        w_state_nxt = S_LOAD;
      end else if (loop && !r_all_zero) begin
        w_idx_nxt      = 2'd0;
        w_all_zero_nxt = 1'b1;
        w_state_nxt    = S_LOAD;
      end else begin
        w_state_nxt = S_DONE;
      end
    end

    if (stop && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tbl_m[i]    <= '0;
        r_tbl_n[i]    <= '0;
        r_tbl_reps[i] <= '0;
      end
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_all_zero  <= 1'b0;
      r_cnt       <= '0;
      r_reps      <= '0;
      r_q_prev    <= 1'b0;
      r_m         <= '0;
      r_n         <= '0;
      r_gen_reset <= 1'b1;
    end else begin
      if (wr_en) begin
        r_tbl_m[wr_addr]    <= wr_m;
        r_tbl_n[wr_addr]    <= wr_n;
        r_tbl_reps[wr_addr] <= wr_reps;
      end
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_all_zero <= w_all_zero_nxt;
      // generator is released only for the cycles the FSM spends in RUN
      r_gen_reset <= (w_state_nxt != S_RUN);
      if (r_state == S_LOAD) begin
        r_m      <= r_tbl_m[r_idx];
        r_n      <= r_tbl_n[r_idx];
        r_reps   <= r_tbl_reps[r_idx];
        r_cnt    <= '0;
        r_q_prev <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_q_prev <= q_in;
        if (w_rise) r_cnt <= w_cnt_inc;
      end
    end
  end

  assign m_out     = r_m;
  assign n_out     = r_n;
  assign gen_reset = r_gen_reset;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign cur_idx   = r_idx;

endmodule

// File: tb/tb_sq_wave_sequencer.sv
// Directed bench for sq_wave_sequencer; q_in rises are driven by hand one cycle at a time.
module tb_sq_wave_sequencer;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, stop, loop, q_in;
  logic [1:0] wr_addr, last_idx, cur_idx;
  logic [3:0] wr_m, wr_n, m_out, n_out;
  logic [7:0] wr_reps;
  logic       gen_reset, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sq_wave_sequencer #(.N(4), .CW(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_m(wr_m), .wr_n(wr_n), .wr_reps(wr_reps),
    .start(start), .stop(stop), .loop(loop), .last_idx(last_idx), .q_in(q_in),
    .m_out(m_out), .n_out(n_out), .gen_reset(gen_reset),
    .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] m, input logic [3:0] n,
                    input logic [7:0] r);
    wr_en = 1'b1; wr_addr = a; wr_m = m; wr_n = n; wr_reps = r;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_q();
    q_in = 1'b1; tick();
    q_in = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_m = '0; wr_n = '0; wr_reps = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; last_idx = '0; q_in = 1'b0;

    // reset state
    do_reset();
    chk("rst_gen_reset", 32'(gen_reset), 1);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_done",      32'(done), 0);
    chk("rst_idx",       32'(cur_idx), 0);
    chk("rst_m",         32'(m_out), 0);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 0);

    // single entry, 2 periods
    wr(2'd0, 4'd3, 4'd2, 8'd2);
    last_idx = 2'd0; loop = 1'b0;
    do_start();
    chk("t1_load_busy", 32'(busy), 1);
    chk("t1_load_gr",   32'(gen_reset), 1);
    tick();
    chk("t1_run_gr", 32'(gen_reset), 0);
    chk("t1_m",      32'(m_out), 3);
    chk("t1_n",      32'(n_out), 2);
    pulse_q();
    chk("t1_rise1_done", 32'(done), 0);
    chk("t1_rise1_gr",   32'(gen_reset), 0);
    q_in = 1'b1; tick();
    chk("t1_done",    32'(done), 1);
    chk("t1_done_gr", 32'(gen_reset), 1);
    q_in = 1'b0; tick();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_done", 32'(done), 0);

    // three entries, middle one skipped
    do_reset();
    wr(2'd0, 4'd1, 4'd1, 8'd1);
    wr(2'd1, 4'd2, 4'd2, 8'd0);
    wr(2'd2, 4'd3, 4'd3, 8'd2);
    last_idx = 2'd2;
    do_start();
    tick();
    chk("t2_idx0", 32'(cur_idx), 0);
    q_in = 1'b1; tick();
    chk("t2_idx1",    32'(cur_idx), 1);
    chk("t2_load1_gr", 32'(gen_reset), 1);
    q_in = 1'b0; tick();
    chk("t2_idx2",      32'(cur_idx), 2);
    chk("t2_load2_gr",  32'(gen_reset), 1);
    tick();
    chk("t2_run2_gr", 32'(gen_reset), 0);
    chk("t2_run2_m",  32'(m_out), 3);
    pulse_q();
    chk("t2_mid_done", 32'(done), 0);
    q_in = 1'b1; tick();
    chk("t2_done", 32'(done), 1);
    q_in = 1'b0; tick();

    // looping pair, then stop mid-RUN
    do_reset();
    wr(2'd0, 4'd1, 4'd1, 8'd1);
    wr(2'd1, 4'd2, 4'd2, 8'd1);
    last_idx = 2'd1; loop = 1'b1;
    do_start();
    tick();
    for (int p = 0; p < 2; p++) begin
      q_in = 1'b1; tick();
      chk("t3_idx1", 32'(cur_idx), 1);
      q_in = 1'b0; tick();
      q_in = 1'b1; tick();
      chk("t3_idx0",  32'(cur_idx), 0);
      chk("t3_nodone", 32'(done), 0);
      q_in = 1'b0; tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t3_stop_busy", 32'(busy), 0);
    chk("t3_stop_gr",   32'(gen_reset), 1);
    chk("t3_stop_done", 32'(done), 0);
    chk("t3_stop_idx",  32'(cur_idx), 0);

    // all entries empty with loop: one pass of LOADs, then DONE
    do_reset();
    last_idx = 2'd3; loop = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) begin
      chk("t4_idx", 32'(cur_idx), 32'(i));
      chk("t4_gr",  32'(gen_reset), 1);
      tick();
    end
    chk("t4_done", 32'(done), 1);
    tick();
    chk("t4_idle", 32'(busy), 0);

    // rewrite during RUN takes effect on the next pass
    do_reset();
    wr(2'd0, 4'd1, 4'd1, 8'd5);
    last_idx = 2'd0; loop = 1'b1;
    do_start();
    tick();
    pulse_q(); pulse_q();
    wr(2'd0, 4'd1, 4'd1, 8'd1);
    start = 1'b1;
    pulse_q();
    start = 1'b0;
    pulse_q();
    chk("t5_still_run", 32'(gen_reset), 0);
    q_in = 1'b1; tick();
    chk("t5_reload_gr", 32'(gen_reset), 1);
    q_in = 1'b0; tick();
    chk("t5_run2_gr", 32'(gen_reset), 0);
    q_in = 1'b1; tick();
    chk("t5_one_rise", 32'(gen_reset), 1);
    q_in = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;

    // reset mid-RUN, then a fresh full run
    do_reset();
    wr(2'd0, 4'd2, 4'd2, 8'd3);
    last_idx = 2'd0; loop = 1'b0;
    do_start();
    tick();
    pulse_q();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_m",    32'(m_out), 0);
    chk("t6_n",    32'(n_out), 0);
    chk("t6_gr",   32'(gen_reset), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_idx",  32'(cur_idx), 0);
    wr(2'd0, 4'd2, 4'd2, 8'd3);
    do_start();
    tick();
    pulse_q(); pulse_q();
    chk("t6_after2", 32'(gen_reset), 0);
    q_in = 1'b1; tick();
    chk("t6_done3", 32'(done), 1);
    q_in = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sq_wave_sequencer.md
SQ_WAVE_SEQUENCER -- requirements
Module: sq_wave_sequencer

Interface
REQ-001 Parameter N, default 4: width of the m/n high/low duration fields driven to the square-wave generator.
REQ-002 Parameter CW, default 8: width of the per-entry repeat (period) count.
REQ-003 Parameter DEPTH, fixed at 4: number of table entries; index width 2.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  table write strobe.
REQ-007 wr_addr  in  2  table entry written.
REQ-008 wr_m, wr_n  in  N each  high/low duration written to the entry.
REQ-009 wr_reps  in  CW  number of full periods the entry runs.
REQ-010 start  in  1  begin sequence at entry 0.
REQ-011 stop  in  1  abort sequence.
REQ-012 loop  in  1  restart at entry 0 after last_idx instead of finishing.
REQ-013 last_idx  in  2  final entry of the sequence.
REQ-014 q_in  in  1  wave output returned from the generator.
REQ-015 m_out, n_out  out  N each  registered duration settings to the generator.
REQ-016 gen_reset  out  1  registered; holds the generator in reset when high.
REQ-017 busy  out  1  sequence active.
REQ-018 done  out  1  one-cycle pulse on normal completion.
REQ-019 cur_idx  out  2  entry currently loaded.

Function
REQ-020 States IDLE, LOAD, RUN, DONE; one-hot or binary encoding is permitted.
REQ-021 Table write: at the clock edge where wr_en=1, {wr_m, wr_n, wr_reps} are stored at wr_addr in any state; the new value takes effect at the next LOAD of that entry, never mid-RUN.
REQ-022 IDLE: gen_reset=1, busy=0; start=1 -> LOAD with cur_idx=0, all_zero flag set.
REQ-023 LOAD (exactly 1 cycle): m_out/n_out <= table[cur_idx], period count <= 0, q_in history <= 0, gen_reset=1, busy=1.
REQ-024 LOAD with reps=0 skips the entry (no RUN cycles) and advances per REQ-027; with reps>0 it goes to RUN and clears all_zero.
REQ-025 RUN: gen_reset=0; a rising edge of q_in (q_in=1, previous-cycle q_in=0) increments the period count.
REQ-026 RUN: the entry ends on the clock where a rising edge brings the count to reps; advance per REQ-027 on that clock.
REQ-027 Advance: cur_idx<last_idx -> cur_idx+1, LOAD; cur_idx==last_idx and loop=1 and all_zero=0 -> cur_idx=0, all_zero set, LOAD; otherwise -> DONE.
REQ-028 DONE (1 cycle): done=1, gen_reset=1, busy=1; next state IDLE.
REQ-029 stop=1 in LOAD, RUN or DONE -> IDLE on the next clock, cur_idx=0, done not asserted; stop has priority over every other transition.
REQ-030 start while busy=1 is ignored; start and stop together in IDLE: stop wins, stay IDLE.
REQ-031 Period counter is CW bits and never wraps: the entry terminates at the count of reps, max 2^CW-1.
REQ-032 Latency: start at cycle t -> LOAD at t+1 -> gen_reset low from t+2.

Reset
REQ-033 reset=1 forces IDLE from any state, including mid-RUN: m_out=0, n_out=0, gen_reset=1, busy=0, done=0, cur_idx=0, period count=0, q_in history=0, all_zero=0.
REQ-034 reset clears every table entry to m=0, n=0, reps=0; reset has priority over wr_en.

Verification
REQ-035 Entry0 {m=3,n=2,reps=2}, last_idx=0, loop=0, start -> 1 LOAD cycle, gen_reset low, done pulses on the clock of the 2nd q_in rise, then IDLE with busy=0.
REQ-036 Entries 0..2 reps {1,0,2}, last_idx=2 -> cur_idx sequence 0,1,2; entry 1 occupies exactly one LOAD cycle with no RUN; done after 3 total rises.
REQ-037 loop=1, last_idx=1, reps {1,1} -> cur_idx 0,1,0,1,... with no done; stop mid-RUN -> IDLE next clock, gen_reset=1, done never seen.
REQ-038 loop=1, all entries reps=0, last_idx=3 -> one pass of 4 LOAD cycles, then DONE; no infinite loop.
REQ-039 Write entry0 reps 5->1 while entry0 is in RUN -> current run still ends at 5 rises; with loop=1, the next pass uses 1.
REQ-040 Assert reset mid-RUN after 1 of 3 rises -> all outputs at reset values next clock; a new start runs the full 3 periods from zero.
